parity_frame_rx: RTL and testbench
==================================

// Module: parity_frame_rx
// PURPOSE
//  Serial receiver and checker for parity-protected byte frames; it is the receive end of the parity generator.
//  Deserialises a framed line (start bit, 8 data bits LSB first, parity bit, stop bit) and recomputes parity.
//  Parity is recomputed as the XOR reduction of the data byte.
//  Presents the byte with a one-cycle valid pulse plus parity and framing error flags.
// PARAMETERS
//  BIT_CYCLES  16  clock cycles per serial bit; legal range 4..255, must be even
//  ODD_PARITY  0   0: expected parity = ^data (even); 1: expected parity = ~^data (odd)
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  sin         in   1  serial line; idles high; asynchronous to clk
//  data        out  8  last received byte; held until the next frame completes
//  valid       out  1  one-cycle pulse when data/flags are updated
//  parity_err  out  1  received parity bit != expected; valid with valid, held
//  frame_err   out  1  stop bit sampled 0; valid with valid, held
//  busy        out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: data=8'h00, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, synchroniser flops=1.
//  sin passes through a 2-flop synchroniser; all logic below uses the synchronised bit s.
//  Bit counter cnt (8 bit) and index idx (3 bit) are cleared on every state entry.
//  FSM:
//   IDLE   : s==0 -> START
//   START  : at cnt==BIT_CYCLES/2-1, sample s.
//            s==1 is a false start -> IDLE with no output; s==0 -> DATA.
//   DATA   : every BIT_CYCLES cycles, shift s into shreg[idx] (LSB first).
//            After idx==7 is sampled -> PARITY.
//   PARITY : sample s into pbit after BIT_CYCLES cycles -> STOP
//   STOP   : sample s after BIT_CYCLES cycles.
//            Next cycle: data<=shreg; parity_err<=pbit^(^shreg)^ODD_PARITY; frame_err<=~s; valid=1 -> IDLE.
//  All samples land mid-bit: START waits half a bit, then each sample is a full bit later.
//  Latency: valid rises 2 (sync) + BIT_CYCLES/2 + 10*BIT_CYCLES + 1 cycles after the start-bit falling edge on sin.
//  A frame is reported even when it has errors; the data byte is updated regardless.
//  frame_err=1: returns to IDLE; a low line re-triggers START, which the false-start check filters.
//  Back-to-back frames: a start bit immediately after the stop bit is accepted.
//   IDLE is re-entered in the valid cycle, with no dead time beyond one cycle.
//  Line held low forever: one frame with frame_err=1, then repeated frames of 8'h00 with frame_err=1.
//  rst_n asserted mid-frame: immediate abort to reset values; the partial frame is never reported.
//  valid is never high for more than one consecutive cycle.
// STRUCTURE
//  Package parity_frame_pkg:
//   - typedef enum logic [2:0] {IDLE,START,DATA,PARITY,STOP} rx_state_t
//   - localparam DATA_BITS=8
//   - function exp_parity(byte, odd) shared with the transmit side
//  Sub-module sync_2ff: 2-flop synchroniser, reset value parameterised (here 1).
//  Everything else stays in a single always_ff plus a next-state always_comb.
// TESTING (BIT_CYCLES=4 allowed for short sims; waveform.vcd dump, $monitor)
//  1. Frame 8'hA7, parity 1, stop 1 -> data=8'hA7, valid pulse, parity_err=0, frame_err=0.
//  2. Frames 8'h00/p0, 8'h03/p0, 8'h15/p1, 8'hFF/p0 back-to-back -> four valid pulses, all flags 0.
//  3. Frame 8'h26 with parity bit 0 (correct is 1) -> data=8'h26, parity_err=1.
//   Same frame with ODD_PARITY=1 -> parity_err=0.
//  4. Frame 8'hB8 with stop bit 0 -> frame_err=1, data=8'hB8.
//  5. sin low pulse of BIT_CYCLES/2-1 cycles while idle -> no valid, busy returns to 0 within one bit.
//  6. rst_n low during DATA of an 8'h15 frame -> outputs at reset values, no valid.
//   Next full 8'h01 frame is received correctly.

Source files
------------

// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity-protected byte frame receiver.
// Both the transmit and receive sides use this package, so the parity rule
// is written once in exp_parity.
//   rx_state_t  : receiver FSM states
//   DATA_BITS   : payload bits per frame
//   exp_parity  : parity bit a correct frame carries for a given byte
package parity_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Even parity makes the XOR of data and parity bit 0; odd parity makes it 1.
  function automatic logic exp_parity(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_rx_sync.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two cycles behind d
module parity_frame_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial receiver for frames of: start bit (0), 8 data bits LSB first,
// parity bit, stop bit (1). Every bit is sampled mid-bit: START waits half a
// bit, then each further sample is one full bit later. Each completed frame
// is reported with a one-cycle valid pulse, even when it carries errors.
// BIT_CYCLES must be even and within 4..255.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   sin        : serial line, idles high, asynchronous to clk
//   data       : last received byte, held until the next frame completes
//   valid      : one-cycle pulse when data and flags update
//   parity_err : received parity bit differs from the expected one
//   frame_err  : stop bit sampled low
//   busy       : frame in progress (FSM not in IDLE)
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int BIT_CYCLES = 16,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [7:0] HALF_LAST = 8'(BIT_CYCLES / 2 - 1);
  localparam logic [7:0] FULL_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);

  rx_state_t             state;
  rx_state_t             state_next;
  logic                  s;
  logic [7:0]            cnt;
  logic [2:0]            idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  pbit;
  logic                  bit_done;

  parity_frame_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sin),
    .q     (s)
  );

  assign bit_done = (cnt == FULL_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!s) state_next = START;
      // A start bit that is high again at mid-bit was a glitch.
      START:   if (cnt == HALF_LAST) state_next = s ? IDLE : DATA;
      DATA:    if (bit_done && idx == IDX_LAST) state_next = PARITY;
      PARITY:  if (bit_done) state_next = STOP;
      STOP:    if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      idx        <= 3'd0;
      shreg      <= '0;
      pbit       <= 1'b0;
      data       <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      state <= state_next;
      busy  <= (state_next != IDLE);

      case (state)
        IDLE: cnt <= 8'd0;
        DATA: begin
          if (bit_done) begin
            shreg[idx] <= s;
            idx        <= idx + 3'd1;
            cnt        <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PARITY: begin
          if (bit_done) pbit <= s;
          cnt <= cnt + 8'd1;
        end
        STOP: begin
          // The frame is reported in the same cycle IDLE is re-entered, so a
          // start bit right after the stop bit is not missed.
          if (bit_done) begin
            data       <= shreg;
            parity_err <= pbit ^ exp_parity(shreg, ODD_PARITY);
            frame_err  <= ~s;
            valid      <= 1'b1;
          end
          cnt <= cnt + 8'd1;
        end
        default: cnt <= cnt + 8'd1;
      endcase

      // Counter and index restart on every state entry.
      if (state_next != state) begin
        cnt <= 8'd0;
        idx <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx. Two receivers (even and odd parity)
// watch the same line; every frame sent pushes the expected report for each
// into its queue, and a monitor pops and compares on every valid pulse.
module tb_parity_frame_rx;

  localparam int BC = 4;

  logic       clk;
  logic       rst_n;
  logic       sin;

  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o;
  logic       perr_e, perr_o;
  logic       ferr_e, ferr_o;
  logic       busy_e, busy_o;

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_q_e[$];
  logic [9:0] exp_q_o[$];
  logic [9:0] exp_e_v, exp_o_v;
  logic       valid_prev_e = 1'b0;
  logic       valid_prev_o = 1'b0;
  int         n_valid_e = 0;
  int         n_valid_o = 0;
  int         n_frames  = 0;

  parity_frame_rx #(.BIT_CYCLES(BC), .ODD_PARITY(1'b0)) dut_even (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .data       (data_e),
    .valid      (valid_e),
    .parity_err (perr_e),
    .frame_err  (ferr_e),
    .busy       (busy_e)
  );

  parity_frame_rx #(.BIT_CYCLES(BC), .ODD_PARITY(1'b1)) dut_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .data       (data_o),
    .valid      (valid_o),
    .parity_err (perr_o),
    .frame_err  (ferr_o),
    .busy       (busy_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (valid_e) begin
      n_valid_e++;
      check("valid_pulse_even", 32'(valid_prev_e), 32'd0);
      if (exp_q_e.size() == 0) begin
        check("unexpected_frame_even", 32'({data_e, perr_e, ferr_e}), 32'h3ff);
      end else begin
        exp_e_v = exp_q_e.pop_front();
        check("frame_even", 32'({data_e, perr_e, ferr_e}), 32'(exp_e_v));
      end
    end
    valid_prev_e = valid_e;
  end

  always @(negedge clk) begin
    if (valid_o) begin
      n_valid_o++;
      check("valid_pulse_odd", 32'(valid_prev_o), 32'd0);
      if (exp_q_o.size() == 0) begin
        check("unexpected_frame_odd", 32'({data_o, perr_o, ferr_o}), 32'h3ff);
      end else begin
        exp_o_v = exp_q_o.pop_front();
        check("frame_odd", 32'({data_o, perr_o, ferr_o}), 32'(exp_o_v));
      end
    end
    valid_prev_o = valid_o;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    sin = b;
    repeat (BC) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    sin = 1'b1;
    repeat (n * BC) @(posedge clk);
    #1;
  endtask

  // perr_even is the hand-computed parity error for the even receiver; the odd
  // receiver's expectation is its complement since its expected bit is inverted.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic st,
                            input logic perr_even, input int gap_bits);
    exp_q_e.push_back({d, perr_even, ~st});
    exp_q_o.push_back({d, ~perr_even, ~st});
    n_frames++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(st);
    if (gap_bits > 0) idle_bits(gap_bits);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q_e.size() != 0 || exp_q_o.size() != 0) && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("drain_even", 32'(exp_q_e.size()), 32'd0);
    check("drain_odd", 32'(exp_q_o.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_even"}, 32'(data_e), 32'h00);
    check({tag, "_data_odd"},  32'(data_o), 32'h00);
    check({tag, "_valid"},     32'({valid_e, valid_o}), 32'd0);
    check({tag, "_perr"},      32'({perr_e, perr_o}), 32'd0);
    check({tag, "_ferr"},      32'({ferr_e, ferr_o}), 32'd0);
    check({tag, "_busy"},      32'({busy_e, busy_o}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_bits(2);

    // 1. A7 carries five ones, parity bit 1 is correct for even parity.
    send_frame(8'hA7, 1'b1, 1'b1, 1'b0, 2);
    drain();
    check("held_data_even", 32'(data_e), 32'hA7);

    // 2. Back-to-back frames, all with correct even parity.
    send_frame(8'h00, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h03, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h15, 1'b1, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 2);
    drain();

    // 3. 26 has three ones; parity bit 0 is wrong for even, right for odd.
    send_frame(8'h26, 1'b0, 1'b1, 1'b1, 2);
    drain();
    check("held_perr_even", 32'(perr_e), 32'd1);
    check("held_perr_odd", 32'(perr_o), 32'd0);

    // 4. B8 with correct even parity but a low stop bit.
    send_frame(8'hB8, 1'b0, 1'b0, 1'b0, 3);
    drain();
    check("held_ferr", 32'({ferr_e, ferr_o}), 32'b11);
    check("idle_after_ferr", 32'({busy_e, busy_o}), 32'd0);

    // 5. Glitch of BC/2-1 cycles while idle: no frame, busy drops within a bit.
    sin = 1'b0;
    @(posedge clk); #1;
    sin = 1'b1;
    repeat (BC + 3) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", 32'({busy_e, busy_o}), 32'd0);
    check("glitch_no_frame", 32'(n_valid_e), 32'(n_frames));
    idle_bits(2);

    // 6. Reset in the middle of the data bits of a 15 frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("busy_mid_frame", 32'({busy_e, busy_o}), 32'b11);
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_bits(2);
    check("midreset_no_frame", 32'(n_valid_e), 32'(n_frames));

    // 01 has one one; parity bit 1 is correct for even parity.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 2);
    drain();
    check("final_data_odd", 32'(data_o), 32'h01);

    check("pulse_count_even", 32'(n_valid_e), 32'(n_frames));
    check("pulse_count_odd", 32'(n_valid_o), 32'(n_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
